lc3_mem_initiator: RTL and testbench

//   CPU-side master for the LC-3 unified memory: takes one load/store request at a time from the

---
 rtl/lc3_mem_pkg.sv | 17 +
 rtl/lc3_mmio_regs.sv | 56 +++++
 rtl/lc3_mem_initiator.sv | 124 ++++++++++++
 tb/tb_lc3_mem_initiator.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared types and device-page addresses for the LC-3 memory initiator.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [15:0] MMIO_BASE = 16'hFE00;
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

endpackage

// File: rtl/lc3_mmio_regs.sv
// LC-3 device page: keyboard status/data latch, display status, and the DDR output pulse.
module lc3_mmio_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        capture,
  input  logic        kb_strobe,
  input  logic [7:0]  kb_data,
  input  logic        disp_ready,
  output logic [15:0] rdata,
  output logic        ddr_valid,
  output logic [7:0]  ddr_data
);
  import lc3_mem_pkg::*;

  logic       kb_ready_q, kb_ready_d;
  logic [7:0] kbd_q, kbd_d;

  // A new keystroke in the same cycle as the KBDR read wins: the read sees the old char.
  always_comb begin
    kb_ready_d = kb_ready_q;
    kbd_d      = kbd_q;
    if (capture && (addr == KBDR_ADDR)) kb_ready_d = 1'b0;
    if (kb_strobe) begin
      kb_ready_d = 1'b1;
      kbd_d      = kb_data;
    end
  end

  always_comb begin
    rdata = 16'h0000;
    case (addr)
      KBSR_ADDR: rdata = {kb_ready_q, 15'b0};
      KBDR_ADDR: rdata = {8'h00, kbd_q};
      DSR_ADDR:  rdata = {disp_ready, 15'b0};
      default:   rdata = 16'h0000;
    endcase
  end

  assign ddr_valid = sel && we && (addr == DDR_ADDR);
  assign ddr_data  = ddr_valid ? wdata : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      kb_ready_q <= 1'b0;
      kbd_q      <= 8'h00;
    end else begin
      kb_ready_q <= kb_ready_d;
      kbd_q      <= kbd_d;
    end
  end

endmodule

// File: rtl/lc3_mem_initiator.sv
// LC-3 CPU-side memory master: latches one request into MAR/MDR, runs the memory port
// with programmable wait states, and routes device-page accesses to lc3_mmio_regs.
module lc3_mem_initiator #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [15:0] MMIO_BASE   = lc3_mem_pkg::MMIO_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [15:0] mem_rdata,
  input  logic        kb_strobe,
  input  logic [7:0]  kb_data,
  input  logic        disp_ready,
  output logic        ddr_valid,
  output logic [7:0]  ddr_data
);
  import lc3_mem_pkg::*;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;
  logic        we_q, we_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;

  logic        is_mmio;
  logic        in_access;
  logic        last_access;
  logic [15:0] dev_rdata;

  assign is_mmio     = (mar_q >= MMIO_BASE);
  assign in_access   = (state_q == ACCESS) || (state_q == WAIT);
  assign last_access = in_access && (wait_cnt_q == 4'd0);

  // NOTE: every variable gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    mar_d      = mar_q;
    mdr_d      = mdr_q;
    we_d       = we_q;
    wait_cnt_d = wait_cnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 16'h0000;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          mar_d      = req_addr;
          mdr_d      = req_wdata;
          we_d       = req_we;
          wait_cnt_d = WAIT_INIT;
          state_d    = ACCESS;
        end
      end
      ACCESS, WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          if (!we_q) mdr_d = is_mmio ? dev_rdata : mem_rdata;
          state_d = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
          state_d    = WAIT;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = we_q ? 16'h0000 : mdr_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Device-page addresses never raise a memory strobe.
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign mem_read  = in_access && !is_mmio && !we_q;
  assign mem_write = in_access && !is_mmio && we_q;

  lc3_mmio_regs u_mmio (
    .clk        (clk),
    .rst        (rst),
    .sel        ((state_q == ACCESS) && is_mmio),
    .we         (we_q),
    .addr       (mar_q),
    .wdata      (mdr_q[7:0]),
    .capture    (last_access && is_mmio && !we_q),
    .kb_strobe  (kb_strobe),
    .kb_data    (kb_data),
    .disp_ready (disp_ready),
    .rdata      (dev_rdata),
    .ddr_valid  (ddr_valid),
    .ddr_data   (ddr_data)
  );

  // NOTE: flops use non-blocking assignment so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mar_q      <= 16'h0000;
      mdr_q      <= 16'h0000;
      we_q       <= 1'b0;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      mar_q      <= mar_d;
      mdr_q      <= mdr_d;
      we_q       <= we_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_lc3_mem_initiator.sv
// Bench for lc3_mem_initiator: a zero-wait and a three-wait instance, each with its own memory
// model and response scoreboard; table-driven transactions plus reset-abort and keyboard-race sequences.
module tb_lc3_mem_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid0, req_valid3, req_we, kb_strobe, disp_ready;
  logic [15:0] req_addr, req_wdata;
  logic [7:0]  kb_data;

  logic        req_ready0, resp_valid0, mem_read0, mem_write0, ddr_valid0;
  logic [15:0] resp_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
  logic [7:0]  ddr_data0;
  logic        req_ready3, resp_valid3, mem_read3, mem_write3, ddr_valid3;
  logic [15:0] resp_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic [7:0]  ddr_data3;

  lc3_mem_initiator #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid0), .resp_rdata(resp_rdata0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_read(mem_read0), .mem_write(mem_write0),
    .mem_rdata(mem_rdata0), .kb_strobe(kb_strobe), .kb_data(kb_data), .disp_ready(disp_ready),
    .ddr_valid(ddr_valid0), .ddr_data(ddr_data0)
  );

  lc3_mem_initiator #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid3), .resp_rdata(resp_rdata3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_read(mem_read3), .mem_write(mem_write3),
    .mem_rdata(mem_rdata3), .kb_strobe(kb_strobe), .kb_data(kb_data), .disp_ready(disp_ready),
    .ddr_valid(ddr_valid3), .ddr_data(ddr_data3)
  );

  // Memory models: combinational read (garbage when not strobed), write on posedge.
  logic [15:0] mem0 [0:65535];
  logic [15:0] mem3 [0:65535];
  assign mem_rdata0 = mem_read0 ? mem0[mem_addr0] : 16'h0BAD;
  assign mem_rdata3 = mem_read3 ? mem3[mem_addr3] : 16'h0BAD;

  always @(posedge clk) begin
    if (rst) begin
      mem0[16'hFDFF] <= 16'hBEEF;
      mem3[16'h4000] <= 16'h00AB;
    end
    if (mem_write0) mem0[mem_addr0] <= mem_wdata0;
    if (mem_write3) mem3[mem_addr3] <= mem_wdata3;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard and activity monitor.
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q3[$];
  int rd_cyc0 = 0, wr_cyc0 = 0, ddr_cnt0 = 0, resp_cnt0 = 0;
  int rd_cyc3 = 0, wr_cyc3 = 0, ddr_cnt3 = 0, resp_cnt3 = 0;
  int mmio_viol = 0;
  logic [7:0] last_ddr0 = 8'h00, last_ddr3 = 8'h00;

  always @(negedge clk) begin
    if (mem_read0)  rd_cyc0 <= rd_cyc0 + 1;
    if (mem_write0) wr_cyc0 <= wr_cyc0 + 1;
    if (mem_read3)  rd_cyc3 <= rd_cyc3 + 1;
    if (mem_write3) wr_cyc3 <= wr_cyc3 + 1;
    if (((mem_read0 || mem_write0) && mem_addr0 >= 16'hFE00) ||
        ((mem_read3 || mem_write3) && mem_addr3 >= 16'hFE00))
      mmio_viol <= mmio_viol + 1;
    if (ddr_valid0) begin ddr_cnt0 <= ddr_cnt0 + 1; last_ddr0 <= ddr_data0; end
    if (ddr_valid3) begin ddr_cnt3 <= ddr_cnt3 + 1; last_ddr3 <= ddr_data3; end
    if (resp_valid0) begin
      resp_cnt0 <= resp_cnt0 + 1;
      if (exp_q0.size() == 0) check("resp0_unexpected", 32'd1, 32'd0);
      else check("resp0_rdata", {16'h0, resp_rdata0}, {16'h0, exp_q0.pop_front()});
    end
    if (resp_valid3) begin
      resp_cnt3 <= resp_cnt3 + 1;
      if (exp_q3.size() == 0) check("resp3_unexpected", 32'd1, 32'd0);
      else check("resp3_rdata", {16'h0, resp_rdata3}, {16'h0, exp_q3.pop_front()});
    end
  end

  task automatic wait_ready(input bit inst);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = inst ? req_ready3 : req_ready0;
    end
    if (!ok) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input bit inst, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
    wait_ready(inst);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    if (inst) req_valid3 = 1'b1;
    else      req_valid0 = 1'b1;
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;
    req_valid3 = 1'b0;
  endtask

  task automatic wait_resp(input bit inst, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      lat  = i;
      seen = inst ? resp_valid3 : resp_valid0;
    end
    if (!seen) check("resp_timeout", 32'd0, 32'd1);
  endtask

  // One full transaction; returns latency and strobe/DDR activity it caused.
  task automatic xact(input string tag, input bit inst, input bit we, input logic [15:0] addr,
                      input logic [15:0] wdata, input logic [15:0] exp,
                      output int lat, output int rd, output int wr, output int dd);
    int rd_s, wr_s, dd_s;
    issue(inst, we, addr, wdata);
    rd_s = inst ? rd_cyc3 : rd_cyc0;
    wr_s = inst ? wr_cyc3 : wr_cyc0;
    dd_s = inst ? ddr_cnt3 : ddr_cnt0;
    if (inst) exp_q3.push_back(exp);
    else      exp_q0.push_back(exp);
    wait_resp(inst, lat);
    check({tag, "_ready_in_resp"}, {31'b0, inst ? req_ready3 : req_ready0}, 32'd0);
    @(negedge clk);
    check({tag, "_ready_after"}, {31'b0, inst ? req_ready3 : req_ready0}, 32'd1);
    rd = (inst ? rd_cyc3 : rd_cyc0) - rd_s;
    wr = (inst ? wr_cyc3 : wr_cyc0) - wr_s;
    dd = (inst ? ddr_cnt3 : ddr_cnt0) - dd_s;
  endtask

  task automatic kb_press(input logic [7:0] c);
    @(negedge clk);
    kb_strobe = 1'b1;
    kb_data   = c;
    @(posedge clk);
    #1;
    kb_strobe = 1'b0;
  endtask

  typedef struct {
    bit          inst;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          disp;
    logic [15:0] exp;
    int          exp_rd;
    int          exp_wr;
    int          exp_ddr;
    logic [7:0]  exp_ddr_data;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  initial begin
    int lat, rd, wr, dd, cnt_s;
    vec_t v;

    vecs[0]  = '{1'b0, 1'b1, 16'h3000, 16'h1234, 1'b1, 16'h0000, 0, 1, 0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 16'h3000, 16'h0000, 1'b1, 16'h1234, 1, 0, 0, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 16'h4000, 16'h0000, 1'b1, 16'h00AB, 4, 0, 0, 8'h00};
    vecs[3]  = '{1'b1, 1'b1, 16'h4001, 16'h5555, 1'b1, 16'h0000, 0, 4, 0, 8'h00};
    vecs[4]  = '{1'b1, 1'b0, 16'h4001, 16'h0000, 1'b1, 16'h5555, 4, 0, 0, 8'h00};
    vecs[5]  = '{1'b0, 1'b0, 16'hFDFF, 16'h0000, 1'b1, 16'hBEEF, 1, 0, 0, 8'h00};
    vecs[6]  = '{1'b0, 1'b1, 16'hFE00, 16'h1111, 1'b1, 16'h0000, 0, 0, 0, 8'h00};
    vecs[7]  = '{1'b0, 1'b0, 16'hFE00, 16'h0000, 1'b1, 16'h0000, 0, 0, 0, 8'h00};
    vecs[8]  = '{1'b0, 1'b1, 16'hFE06, 16'h0058, 1'b1, 16'h0000, 0, 0, 1, 8'h58};
    vecs[9]  = '{1'b1, 1'b1, 16'hFE06, 16'h0141, 1'b1, 16'h0000, 0, 0, 1, 8'h41};
    vecs[10] = '{1'b0, 1'b0, 16'hFE04, 16'h0000, 1'b1, 16'h8000, 0, 0, 0, 8'h00};
    vecs[11] = '{1'b1, 1'b0, 16'hFE04, 16'h0000, 1'b0, 16'h0000, 0, 0, 0, 8'h00};
    vecs[12] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 0, 0, 0, 8'h00};
    vecs[13] = '{1'b0, 1'b1, 16'hFFFF, 16'hAAAA, 1'b1, 16'h0000, 0, 0, 0, 8'h00};
    vecs[14] = '{1'b0, 1'b0, 16'hFE08, 16'h0000, 1'b1, 16'h0000, 0, 0, 0, 8'h00};

    rst = 1'b1; req_valid0 = 1'b0; req_valid3 = 1'b0; req_we = 1'b0;
    req_addr = 16'h0; req_wdata = 16'h0; kb_strobe = 1'b0; kb_data = 8'h0; disp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    check("rst_ready0", {31'b0, req_ready0}, 32'd1);
    check("rst_ready3", {31'b0, req_ready3}, 32'd1);
    check("rst_strobes0", {29'b0, resp_valid0, mem_read0, mem_write0}, 32'd0);
    check("rst_strobes3", {29'b0, resp_valid3, mem_read3, mem_write3}, 32'd0);
    check("rst_data0", {mem_addr0, mem_wdata0}, 32'd0);
    check("rst_rdata0", {16'h0, resp_rdata0}, 32'd0);
    check("rst_ddr0", {23'b0, ddr_valid0, ddr_data0}, 32'd0);
    check("rst_ddr3", {23'b0, ddr_valid3, ddr_data3}, 32'd0);

    for (int k = 0; k < NVEC; k++) begin
      v = vecs[k];
      disp_ready = v.disp;
      xact($sformatf("v%0d", k), v.inst, v.we, v.addr, v.wdata, v.exp, lat, rd, wr, dd);
      check($sformatf("v%0d_latency", k), lat, v.inst ? 32'd5 : 32'd2);
      check($sformatf("v%0d_rd_cycles", k), rd, v.exp_rd);
      check($sformatf("v%0d_wr_cycles", k), wr, v.exp_wr);
      check($sformatf("v%0d_ddr_pulses", k), dd, v.exp_ddr);
      if (v.exp_ddr != 0)
        check($sformatf("v%0d_ddr_data", k), {24'b0, v.inst ? last_ddr3 : last_ddr0},
              {24'b0, v.exp_ddr_data});
    end
    disp_ready = 1'b1;

    // Keyboard: status, data read, status cleared by the data read.
    kb_press(8'h41);
    xact("kbsr_set", 1'b0, 1'b0, 16'hFE00, 16'h0, 16'h8000, lat, rd, wr, dd);
    xact("kbdr_41", 1'b0, 1'b0, 16'hFE02, 16'h0, 16'h0041, lat, rd, wr, dd);
    check("kbdr_no_mem_read", rd, 32'd0);
    xact("kbsr_clr", 1'b0, 1'b0, 16'hFE00, 16'h0, 16'h0000, lat, rd, wr, dd);

    // Keystroke lands on the KBDR capture edge: old char returned, new char kept pending.
    kb_press(8'h41);
    issue(1'b0, 1'b0, 16'hFE02, 16'h0);
    exp_q0.push_back(16'h0041);
    @(negedge clk);
    kb_strobe = 1'b1;
    kb_data   = 8'h42;
    @(posedge clk);
    #1 kb_strobe = 1'b0;
    wait_resp(1'b0, lat);
    check("race_latency", lat, 32'd1);
    xact("race_kbsr", 1'b0, 1'b0, 16'hFE00, 16'h0, 16'h8000, lat, rd, wr, dd);
    xact("race_kbdr", 1'b0, 1'b0, 16'hFE02, 16'h0, 16'h0042, lat, rd, wr, dd);
    xact("race_kbsr_clr", 1'b0, 1'b0, 16'hFE00, 16'h0, 16'h0000, lat, rd, wr, dd);

    // Reset during WAIT of a store aborts it with no response.
    issue(1'b1, 1'b1, 16'h5000, 16'h7777);
    @(negedge clk);
    @(negedge clk);
    check("abort_pre_write", {31'b0, mem_write3}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    cnt_s = resp_cnt3;
    @(negedge clk);
    check("abort_strobes", {30'b0, mem_read3, mem_write3}, 32'd0);
    check("abort_ready", {31'b0, req_ready3}, 32'd1);
    check("abort_mar", {16'h0, mem_addr3}, 32'd0);
    repeat (8) @(negedge clk);
    check("abort_no_resp", resp_cnt3 - cnt_s, 32'd0);
    xact("post_abort", 1'b1, 1'b0, 16'h4000, 16'h0, 16'h00AB, lat, rd, wr, dd);
    check("post_abort_latency", lat, 32'd5);

    repeat (2) @(negedge clk);
    check("sb0_drained", exp_q0.size(), 32'd0);
    check("sb3_drained", exp_q3.size(), 32'd0);
    check("mmio_never_strobed", mmio_viol, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
